// File: rtl/count_sequence_checker_pkg.sv
// rtl/count_sequence_checker_pkg.sv - shared state, count and mode encodings
package count_sequence_checker_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [2:0] CNT_A = 3'd0;
    localparam logic [2:0] CNT_B = 3'd1;
    localparam logic [2:0] CNT_C = 3'd2;
    localparam logic [2:0] CNT_D = 3'd3;
    localparam logic [2:0] CNT_E = 3'd4;
    localparam logic [2:0] CNT_F = 3'd5;
    localparam logic [2:0] CNT_G = 3'd6;
    localparam logic [2:0] CNT_H = 3'd7;

    localparam logic MODE_SEQ = 1'b0;
    localparam logic MODE_ALT = 1'b1;

endpackage

// File: rtl/count_sequence_checker_if.sv
// rtl/count_sequence_checker_if.sv - sample inputs and checker status bundle
interface count_sequence_checker_if #(
    parameter int ERR_W = 8,
    parameter int LAP_W = 8
);
    logic [2:0]       count_in;
    logic             mode_in;
    logic             clear;
    logic             synced;
    logic [2:0]       expected;
    logic             mismatch;
    logic             fault;
    logic [ERR_W-1:0] err_count;
    logic [LAP_W-1:0] lap_count;

    modport master (
        output count_in, mode_in, clear,
        input  synced, expected, mismatch, fault, err_count, lap_count
    );

    modport slave (
        input  count_in, mode_in, clear,
        output synced, expected, mismatch, fault, err_count, lap_count
    );
endinterface

// File: rtl/count_sequence_checker_lut.sv
// rtl/count_sequence_checker_lut.sv - legal next count of the mode-controlled counter
module count_next_lut
    import count_sequence_checker_pkg::*;
(
    input  logic [2:0] count,
    input  logic       mode,
    output logic [2:0] next
);
    always_comb begin
        next = count + 3'd1;
        // Alternate mode: holds on A,B,D,E,F and the C->G->H->F detour
        if (mode == MODE_ALT) begin
            case (count)
                CNT_C:   next = CNT_G;
                CNT_G:   next = CNT_H;
                CNT_H:   next = CNT_F;
                default: next = count;
            endcase
        end
    end
endmodule

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - falling-edge monitor of counter transitions
module count_sequence_checker
    import count_sequence_checker_pkg::*;
#(
    parameter int ERR_W        = 8,
    parameter int LAP_W        = 8,
    parameter int FAULT_THRESH = 3
) (
    input logic                     clock,
    input logic                     nreset,
    count_sequence_checker_if.slave bus
);
    state_t           state_q, state_d;
    logic [2:0]       prev_count_q, prev_count_d;
    logic             prev_mode_q, prev_mode_d;
    logic [3:0]       consec_q, consec_d;
    logic [2:0]       expected_q, expected_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic [2:0]       lut_next;
    logic             hit;

    count_next_lut u_lut (
        .count (bus.count_in),
        .mode  (bus.mode_in),
        .next  (lut_next)
    );

    assign hit = (bus.count_in == expected_q);

    always_ff @(negedge clock or posedge nreset) begin
        if (nreset) begin
            state_q      <= UNSYNC;
            prev_count_q <= '0;
            prev_mode_q  <= 1'b0;
            consec_q     <= '0;
            expected_q   <= '0;
            mismatch_q   <= 1'b0;
            err_q        <= '0;
            lap_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_mode_q  <= prev_mode_d;
            consec_q     <= consec_d;
            expected_q   <= expected_d;
            mismatch_q   <= mismatch_d;
            err_q        <= err_d;
            lap_q        <= lap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_count_d = prev_count_q;
        prev_mode_d  = prev_mode_q;
        consec_d     = consec_q;
        expected_d   = expected_q;
        mismatch_d   = 1'b0;
        err_d        = err_q;
        lap_d        = lap_q;
        if (bus.clear) begin
            state_d    = UNSYNC;
            consec_d   = '0;
            expected_d = '0;
            err_d      = '0;
            lap_d      = '0;
        end else begin
            case (state_q)
                UNSYNC: begin
                    prev_count_d = bus.count_in;
                    prev_mode_d  = bus.mode_in;
                    expected_d   = lut_next;
                    state_d      = SYNC;
                end
                SYNC: begin
                    // Always rebase on the observed sample so one bad jump costs one error
                    prev_count_d = bus.count_in;
                    prev_mode_d  = bus.mode_in;
                    expected_d   = lut_next;
                    if (hit) begin
                        consec_d = '0;
                        if (prev_count_q == CNT_H && bus.count_in == CNT_A &&
                            prev_mode_q == MODE_SEQ)
                            lap_d = lap_q + 1'b1;
                    end else begin
                        mismatch_d = 1'b1;
                        consec_d   = consec_q + 4'd1;
                        if (err_q != '1)
                            err_d = err_q + 1'b1;
                        if (consec_q + 4'd1 == 4'(FAULT_THRESH))
                            state_d = FAULT;
                    end
                end
                FAULT: begin
                end
                default: state_d = UNSYNC;
            endcase
        end
    end

    assign bus.synced    = (state_q == SYNC);
    assign bus.fault     = (state_q == FAULT);
    assign bus.expected  = expected_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.err_count = err_q;
    assign bus.lap_count = lap_q;
endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
Downstream monitor for the 3-bit mode-controlled complex counter. It samples the counter's count output and mode input on every falling clock edge. It predicts the legal next count from the previous sample and flags illegal transitions. It also keeps saturating error and wrapping lap statistics, and latches a fault after repeated consecutive mismatches.

Parameters:
ERR_W, 8, width of error counter (saturating)
LAP_W, 8, width of lap counter (wrapping)
FAULT_THRESH, 3, consecutive mismatches that force FAULT (legal range 1..15)

Ports:
clock  input  1  system clock, all state updates on falling edge
nreset  input  1  asynchronous, active-high reset (asserted 1 resets, despite the name)
count_in  input  3  count value from upstream counter
mode_in  input  1  mode value driving upstream counter (0 = sequential, 1 = alternate)
clear  input  1  synchronous clear of statistics and FSM, sampled on falling edge
synced  output  1  high while FSM is in SYNC
expected  output  3  predicted value for the next sample (valid when synced = 1)
mismatch  output  1  one-cycle pulse: last sample differed from prediction
fault  output  1  high while FSM is in FAULT
err_count  output  ERR_W  total mismatches since reset/clear, saturates at all-ones
lap_count  output  LAP_W  count of 7->0 wraps observed in SYNC, wraps to 0

Behaviour:
- Reset (nreset = 1, async):
  - FSM = UNSYNC; prev_count = 0, prev_mode = 0, consec = 0.
  - All outputs 0.
- Next-count function nxt(c, m), decided; shared constant table:
  - m = 0: c+1 mod 8 (7 -> 0).
  - m = 1: 0->0, 1->1, 2->6, 3->3, 4->4, 5->5, 6->7, 7->5.
- expected = nxt(prev_count, prev_mode); registered, updated on the same edge that loads prev.
- FSM states, all transitions on the falling edge:
  - UNSYNC: capture prev <= (count_in, mode_in); go to SYNC. No compare.
  - SYNC, match (count_in == expected):
    - consec <= 0.
    - If prev_count = 7 and count_in = 0 and prev_mode = 0: lap_count += 1.
  - SYNC, mismatch:
    - mismatch = 1 for exactly one cycle; err_count += 1 (saturate); consec += 1.
    - If consec + 1 == FAULT_THRESH: go to FAULT.
  - SYNC, every sample: prev <= (count_in, mode_in). This rebases on the observed value, so one illegal jump yields exactly one error, not a cascade.
  - FAULT: fault = 1. No compares, mismatch = 0, counters frozen. Leave only via clear or reset.
- clear = 1:
  - Next state UNSYNC; err_count, lap_count, consec, mismatch, expected all 0.
  - clear has priority over a simultaneous mismatch or lap increment.
- Latency: sample at edge k -> mismatch/err_count/lap_count visible after edge k; mismatch drops after edge k+1 unless k+1 also mismatches.
- Self-loops in mode 1 (0, 1, 3, 4, 5) are legal holds, not errors.
- A mode change is legal at any sample; the prediction always uses the mode paired with the previous count.
- Reset mid-operation: immediate return to reset values; the first post-reset sample is capture-only.

Decomposition:
- Shared package: state encoding constants (UNSYNC = 2'd0, SYNC = 2'd1, FAULT = 2'd2), the 3-bit count encodings A..H = 0..7 already used by the counter, and MODE_SEQ = 0 / MODE_ALT = 1.
- One combinational sub-module, count_next_lut (in: count[2:0], mode; out: next[2:0]). It encodes nxt() and is reusable by the counter itself and by bench models.

Test Plan:
- Reset, then mode_in = 0, count_in 0,1,...,7,0,1 -> synced = 1 after first edge, mismatch never asserts, lap_count = 1, err_count = 0.
- mode_in = 1, count_in 2,6,7,5,5 -> no mismatch; expected shows 6,7,5,5 in turn.
- mode_in = 0, count_in 3,4,6,7 -> single mismatch pulse on the 6 sample, err_count = 1, no further errors (rebased).
- FAULT_THRESH = 3, mode_in = 0, count_in 0,3,6,1 (three bad jumps) -> err_count = 3, fault = 1, synced = 0; further samples leave err_count at 3.
- In FAULT, pulse clear -> next edge: fault = 0, err_count = 0, lap_count = 0, state UNSYNC, then SYNC one edge later.
- ERR_W = 2, inject 5 isolated mismatches -> err_count saturates at 3. Assert nreset asynchronously mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
